// File: rtl/fp_mac_seq.sv
// ---------------------------------------------------------------------------
// fp_mac_seq : issue sequencer for the FP MAC pipeline (one element in flight)
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_mac_seq #(
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [CNT_W-1:0]      len,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  issue,
  output logic                  acc_sel,
  output logic [PIPE_DEPTH-1:0] stage_valid,
  output logic                  acc_we,
  output logic [CNT_W-1:0]      cnt,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PIPE_DEPTH-1:0] stage_valid_q, stage_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic                  abort_act;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      stage_valid_q <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
    end else begin
      state_q       <= state_d;
      stage_valid_q <= stage_valid_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    abort_act     = abort && (state_q != S_IDLE);
    in_ready      = (state_q == S_ISSUE) && !abort_act;
    issue         = in_valid && in_ready;
    acc_sel       = (cnt_q != '0);
    acc_we        = stage_valid_q[PIPE_DEPTH-1] && !abort_act;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE) && !abort_act;
    stage_valid_d = {stage_valid_q[PIPE_DEPTH-2:0], issue};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = (len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Next issue must wait for write-back: it consumes this result.
        if (acc_we) begin
          state_d = (cnt_q == len_q) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_act) begin
      state_d       = S_IDLE;
      stage_valid_d = '0;
    end
  end

  assign stage_valid = stage_valid_q;
  assign cnt         = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_mac_seq : directed + random checks of fp_mac_seq against a timing model
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_mac_seq;

  localparam int P = 4;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] len;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic         issue;
  logic         acc_sel;
  logic [P-1:0] stage_valid;
  logic         acc_we;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;

  fp_mac_seq #(.PIPE_DEPTH(P), .CNT_W(W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .issue      (issue),
    .acc_sel    (acc_sel),
    .stage_valid(stage_valid),
    .acc_we     (acc_we),
    .cnt        (cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Reference: a job is a start time, a length, a handshake count and the
  // time of the latest handshake; all outputs follow from timing rules.
  bit m_active;
  int m_len, m_n, m_th, m_ts, m_cnt;
  int n_iss, n_we, n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_len = 0; m_n = 0; m_th = -100; m_ts = -100; m_cnt = 0;
  endtask

  task automatic clr_counts();
    n_iss = 0; n_we = 0; n_done = 0;
  endtask

  task automatic tick(input bit st, input int ln, input bit ab, input bit iv);
    bit e_ready, e_issue, e_we, e_done, in_iss, ab_act;
    int rt, d, e_sv;
    start = st; len = ln[W-1:0]; abort = ab; in_valid = iv;
    #1;
    ab_act  = ab && m_active;
    rt      = (m_n == 0) ? m_ts + 1 : m_th + P + 1;
    in_iss  = m_active && (m_n < m_len) && (t >= rt);
    e_ready = in_iss && !ab_act;
    e_issue = e_ready && iv;
    d       = t - m_th - 1;
    e_sv    = (d >= 0 && d < P) ? (1 << d) : 0;
    e_we    = (d == P - 1) && !ab_act;
    e_done  = m_active && (m_n == m_len) && (t == rt) && !ab_act;
    chk("in_ready",    32'(in_ready),    32'(e_ready));
    chk("issue",       32'(issue),       32'(e_issue));
    chk("stage_valid", 32'(stage_valid), 32'(e_sv));
    chk("acc_we",      32'(acc_we),      32'(e_we));
    chk("done",        32'(done),        32'(e_done));
    chk("busy",        32'(busy),        32'(m_active));
    chk("cnt",         32'(cnt),         32'(m_cnt));
    if (in_iss) chk("acc_sel", 32'(acc_sel), 32'(m_n != 0));
    n_iss  += int'(issue);
    n_we   += int'(acc_we);
    n_done += int'(done);
    if (ab_act) begin
      m_active = 1'b0;
      m_th     = -100;
    end else if (m_active) begin
      if (e_issue) begin
        m_n++; m_cnt++; m_th = t;
      end
      if (e_done) m_active = 1'b0;
    end else if (st) begin
      m_active = 1'b1;
      m_ts = t; m_len = int'(ln[W-1:0]); m_n = 0; m_cnt = 0; m_th = -100;
    end
    @(posedge clock); #1;
    t++;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sv"},    32'(stage_valid), 32'(0));
    chk({tag, "_cnt"},   32'(cnt),         32'(0));
    chk({tag, "_busy"},  32'(busy),        32'(0));
    chk({tag, "_done"},  32'(done),        32'(0));
    chk({tag, "_ready"}, 32'(in_ready),    32'(0));
    chk({tag, "_issue"}, 32'(issue),       32'(0));
    chk({tag, "_we"},    32'(acc_we),      32'(0));
  endtask

  task automatic run_job(input int budget, input bit iv_rand);
    for (int k = 0; k < budget && m_active; k++)
      tick(1'b0, 0, 1'b0, iv_rand ? ($urandom % 4 != 0) : 1'b1);
    chk("job_end_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b1;
    model_reset();
    clr_counts();
    @(posedge clock); @(posedge clock); #1;
    check_reset_vals("rst");
    resetn = 1'b1;

    // Reset in the middle of a job, while stage_valid = 0100.
    tick(1'b1, 2, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    #1;
    chk("pre_rst_sv", 32'(stage_valid), 32'(4));
    resetn = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    model_reset();
    @(posedge clock); #1; t++;
    resetn = 1'b1;

    // Single element.
    clr_counts();
    tick(1'b1, 1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b0, 0, 1'b0, 1'b1);
    chk("t2_issues", 32'(n_iss), 32'(1));
    chk("t2_we",     32'(n_we),  32'(1));
    chk("t2_done",   32'(n_done), 32'(1));

    // len=3 back to back.
    clr_counts();
    tick(1'b1, 3, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) tick(1'b0, 0, 1'b0, 1'b1);
    chk("t3_issues", 32'(n_iss), 32'(3));
    chk("t3_we",     32'(n_we),  32'(3));
    chk("t3_done",   32'(n_done), 32'(1));
    chk("t3_cnt",    32'(cnt),   32'(3));

    // len=0.
    clr_counts();
    tick(1'b1, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b0, 0, 1'b0, 1'b1);
    chk("t4_issues", 32'(n_iss), 32'(0));
    chk("t4_done",   32'(n_done), 32'(1));

    // Back-pressure.
    clr_counts();
    tick(1'b1, 2, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) tick(1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) tick(1'b0, 0, 1'b0, 1'b1);
    chk("t5_issues", 32'(n_iss), 32'(2));
    chk("t5_done",   32'(n_done), 32'(1));

    // Ignored start while busy, then abort at stage_valid = 0010.
    clr_counts();
    tick(1'b1, 3, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b1, 7, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b0, 0, 1'b0, 1'b1);
    chk("t6_issues", 32'(n_iss), 32'(1));
    chk("t6_we",     32'(n_we),  32'(0));
    chk("t6_done",   32'(n_done), 32'(0));

    // Random jobs with stray starts, len changes and aborts.
    for (int j = 0; j < 12; j++) begin
      tick(1'b1, int'($urandom % 6), ($urandom % 4 == 0), 1'b1);
      for (int k = 0; k < 60; k++)
        tick(($urandom % 6 == 0), int'($urandom % 8), ($urandom % 40 == 0),
             ($urandom % 4 != 0));
      run_job(60, 1'b1);
      tick(1'b0, 0, 1'b0, 1'b0);
    end

    // Maximum length: cnt must reach 255 without wrapping.
    clr_counts();
    tick(1'b1, 255, 1'b0, 1'b1);
    run_job(1400, 1'b0);
    chk("max_cnt",    32'(cnt),   32'(255));
    chk("max_issues", 32'(n_iss), 32'(255));
    chk("max_done",   32'(n_done), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
